// File: rtl/sent_tx_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sent_tx_frame_ctrl
// Purpose  : Sequences one SENT transmit frame at a time on a single-wire
//            output: sync pulse, status nibble, six data nibbles, CRC nibble
//            and an optional pause pulse. Pulse timing is taken from the
//            rising edges of an external tick square wave whose divide
//            setting this block owns and only changes at frame start.
// Ports    : clk_tx / reset_n_tx   - clock, asynchronous active-low reset
//            ticks_i               - tick square wave (one tick = rising edge)
//            divide_o              - divide value driven to tick generator
//            divide_cfg_i          - divide value taken at frame start
//            enable_i              - permits new frames to start
//            pause_en_i            - pad frame to FRAME_TICKS with a pause
//            data_valid_i/_ready_o - payload handshake (ready = 1-cycle pulse)
//            status_i, data_i      - payload nibbles ([23:20] sent first)
//            sent_o                - SENT line, idles high
//            busy_o, frame_done_o  - frame in progress / end-of-frame pulse
// Revision : 1.0 - initial release
// ============================================================================
module sent_tx_frame_ctrl #(
  parameter logic [7:0]  DEFAULT_DIV = 8'd4,
  parameter logic [15:0] FRAME_TICKS = 16'd300,
  parameter int          LOW_TICKS   = 5
) (
  input  logic        clk_tx,
  input  logic        reset_n_tx,
  input  logic        ticks_i,
  output logic [7:0]  divide_o,
  input  logic [7:0]  divide_cfg_i,
  input  logic        enable_i,
  input  logic        pause_en_i,
  input  logic        data_valid_i,
  output logic        data_ready_o,
  input  logic [3:0]  status_i,
  input  logic [23:0] data_i,
  output logic        sent_o,
  output logic        busy_o,
  output logic        frame_done_o
);

  localparam logic [15:0] c_LOW_TICKS  = 16'(LOW_TICKS);
  localparam logic [15:0] c_SYNC_TICKS = 16'd56;
  localparam logic [15:0] c_MIN_TICKS  = 16'd12;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SYNC   = 3'd1,
    S_STATUS = 3'd2,
    S_DATA   = 3'd3,
    S_CRC    = 3'd4,
    S_PAUSE  = 3'd5
  } state_t;

  state_t      r_state, w_state_nxt;
  logic        r_ticks_q;
  logic [3:0]  r_status;
  logic [23:0] r_data;
  logic [3:0]  r_crc;
  logic        r_pause;
  logic [2:0]  r_nib;
  logic [15:0] r_cnt;        // ticks already spent in the current pulse
  logic [15:0] r_frame_cnt;  // ticks since sync start, through CRC
  logic [15:0] r_pause_len;
  logic        r_sent;
  logic        r_done;
  logic [7:0]  r_divide;

  logic        w_tick_stb;
  logic        w_accept;
  logic        w_last;
  logic        w_frame_end;
  logic [15:0] w_len;
  logic [23:0] w_data_sh;
  logic [15:0] w_used;
  logic [15:0] w_pause_calc;

  // CRC over the six data nibbles MSB-first plus four augmenting zeros.
  function automatic logic [3:0] f_crc(input logic [23:0] d);
    logic [27:0] m;
    logic [3:0]  c;
    logic        msb;
    m = {d, 4'b0000};
    c = 4'b0101;
    for (int i = 27; i >= 0; i--) begin
      msb = c[3];
      c   = {c[2:0], m[i]};
      if (msb) c = c ^ 4'b1101;
    end
    return c;
  endfunction

  assign w_tick_stb = ticks_i & ~r_ticks_q;
  // Current data nibble is brought to the top of the word by shifting.
  assign w_data_sh  = r_data << {r_nib, 2'b00};
  assign w_used     = r_frame_cnt + 16'd1;
  assign w_pause_calc = ((w_used + c_MIN_TICKS) > FRAME_TICKS) ? c_MIN_TICKS
                                                               : (FRAME_TICKS - w_used);

  // Length of the pulse belonging to the current state.
  always_comb begin
    w_len = c_MIN_TICKS;
    case (r_state)
      S_SYNC:   w_len = c_SYNC_TICKS;
      S_STATUS: w_len = c_MIN_TICKS + {12'd0, r_status};
      S_DATA:   w_len = c_MIN_TICKS + {12'd0, w_data_sh[23:20]};
      S_CRC:    w_len = c_MIN_TICKS + {12'd0, r_crc};
      S_PAUSE:  w_len = r_pause_len;
      default:  w_len = c_MIN_TICKS;
    endcase
  end

  // Next-state and handshake decode. A new frame is held off during the
  // frame_done_o cycle so acceptance lands on the following cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_last      = (r_cnt == (w_len - 16'd1));
    w_frame_end = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (enable_i && data_valid_i && !r_done) begin
          w_accept    = 1'b1;
          w_state_nxt = S_SYNC;
        end
      end
      S_SYNC:   if (w_tick_stb && w_last) w_state_nxt = S_STATUS;
      S_STATUS: if (w_tick_stb && w_last) w_state_nxt = S_DATA;
      S_DATA:   if (w_tick_stb && w_last && (r_nib == 3'd5)) w_state_nxt = S_CRC;
      S_CRC: begin
        if (w_tick_stb && w_last) begin
          w_state_nxt = r_pause ? S_PAUSE : S_IDLE;
          w_frame_end = ~r_pause;
        end
      end
      S_PAUSE: begin
        if (w_tick_stb && w_last) begin
          w_state_nxt = S_IDLE;
          w_frame_end = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_tx or negedge reset_n_tx) begin
    if (!reset_n_tx) r_state <= S_IDLE;
    else             r_state <= w_state_nxt;
  end

  always_ff @(posedge clk_tx or negedge reset_n_tx) begin
    if (!reset_n_tx) begin
      r_ticks_q   <= 1'b0;
      r_status    <= 4'd0;
      r_data      <= 24'd0;
      r_crc       <= 4'd0;
      r_pause     <= 1'b0;
      r_nib       <= 3'd0;
      r_cnt       <= 16'd0;
      r_frame_cnt <= 16'd0;
      r_pause_len <= 16'd0;
      r_sent      <= 1'b1;
      r_done      <= 1'b0;
      r_divide    <= DEFAULT_DIV;
    end else begin
      r_ticks_q <= ticks_i;
      r_done    <= w_frame_end;
      if (w_accept) begin
        r_status <= status_i;
        r_data   <= data_i;
        r_pause  <= pause_en_i;
        r_divide <= divide_cfg_i;
        r_crc    <= f_crc(data_i);
        r_nib    <= 3'd0;
        r_cnt    <= 16'd0;
      end
      if (w_tick_stb && (r_state != S_IDLE)) begin
        // r_cnt == 0 means this tick is the first one of a new pulse.
        if (r_cnt == 16'd0)        r_sent <= 1'b0;
        if (r_cnt == c_LOW_TICKS)  r_sent <= 1'b1;
        r_cnt <= w_last ? 16'd0 : (r_cnt + 16'd1);
        if ((r_state == S_DATA) && w_last) r_nib <= r_nib + 3'd1;
        if ((r_state == S_SYNC) && (r_cnt == 16'd0))
          r_frame_cnt <= 16'd1;
        else if (r_state != S_PAUSE)
          r_frame_cnt <= r_frame_cnt + 16'd1;
        if ((r_state == S_CRC) && w_last) r_pause_len <= w_pause_calc;
        if (w_frame_end) r_sent <= 1'b1;
      end
    end
  end

  assign divide_o     = r_divide;
  assign data_ready_o = w_accept;
  assign sent_o       = r_sent;
  assign busy_o       = (r_state != S_IDLE);
  assign frame_done_o = r_done;

endmodule
`default_nettype wire

// File: doc/sent_tx_frame_ctrl.md
Name: sent_tx_frame_ctrl

Overview:
Sequences one SENT (SAE J2716-style) transmit frame at a time on the single-wire output:
- frame order: sync pulse, status nibble, six data nibbles, CRC nibble, optional pause pulse.
- timing comes from the tick square wave produced by the tick generator.
- this block drives the generator's divide setting and changes it only between frames.
- upstream logic supplies frame payloads through a valid/ready handshake.

Parameters:
DEFAULT_DIV, 8'd4, divide value driven to the tick generator after reset.
FRAME_TICKS, 16'd300, total frame length in ticks when pause is enabled; must be ≥284.
LOW_TICKS, 5, low-phase length of every pulse, in ticks.

Ports:
clk_tx  input  1  transmitter clock.
reset_n_tx  input  1  asynchronous active-low reset.
ticks_i  input  1  tick square wave from the tick generator; one tick = one rising edge.
divide_o  output  8  divide value to the tick generator.
divide_cfg_i  input  8  requested divide value, sampled at frame start.
enable_i  input  1  permits new frames to start.
pause_en_i  input  1  append pause pulse so the frame lasts FRAME_TICKS; sampled at frame start.
data_valid_i  input  1  payload available.
data_ready_o  output  1  one-cycle pulse: payload accepted this cycle.
status_i  input  4  status nibble.
data_i  input  24  data nibbles; [23:20] is sent first.
sent_o  output  1  SENT line; idles high.
busy_o  output  1  frame in progress.
frame_done_o  output  1  one-cycle pulse at frame end.

Behaviour:
- Asynchronous reset gives: sent_o=1, busy_o=0, data_ready_o=0, frame_done_o=0, divide_o=DEFAULT_DIV, state IDLE, all counters 0.
- Tick strobe:
  - tick_stb = ticks_i & ~ticks_q, where ticks_q is ticks_i registered on clk_tx.
  - all tick counting advances only on tick_stb.
- Frame start, in IDLE:
  - condition: enable_i & data_valid_i.
  - same cycle: data_ready_o=1; latch status_i, data_i and pause_en_i; latch divide_cfg_i into divide_o.
  - busy_o=1 from the next cycle.
  - the first tick_stb afterwards begins SYNC.
- States: IDLE -> SYNC -> STATUS -> DATA (6 nibbles, nibble index 0..5) -> CRC -> PAUSE (only if pause latched) -> IDLE.
- Pulse shape:
  - each pulse is LOW_TICKS ticks low, then high for the rest of its length.
  - sent_o changes on the clk_tx edge after the tick_stb that starts each phase.
- Pulse lengths:
  - SYNC = 56 ticks.
  - nibble value N = 12+N ticks.
  - CRC uses the same nibble rule.
  - PAUSE = FRAME_TICKS − (ticks used by sync through CRC), with a minimum of 12.
- Frame tick counter:
  - 16 bits, cleared at SYNC start.
  - counts every tick through the end of CRC.
- CRC:
  - 4-bit, polynomial x^4+x^3+x^2+1 (feedback 4'b1101), seed 4'b0101.
  - covers the 6 data nibbles MSB-first, then 4 augmenting zero bits; the status nibble is excluded.
  - per-bit update: msb=crc[3]; crc={crc[2:0],bit}; if msb, crc^=4'b1101.
  - may be computed at frame start (combinational or iterative); the result must be ready before CRC state begins.
- Frame end:
  - at the last tick of the final pulse: frame_done_o pulses 1 cycle, state returns to IDLE, busy_o=0, sent_o=1.
  - back-to-back frames: a new frame may be accepted the cycle after frame_done_o.
- enable_i deasserted mid-frame: the current frame completes normally, then no new frame starts.
- data_valid_i low in IDLE: the line stays high indefinitely.
- divide_cfg_i changes mid-frame: ignored until the next frame start.
- Reset asserted mid-frame: the frame is aborted immediately and all outputs take their reset values.
- ticks_i stuck: state is frozen; no timeout.

Test Plan:
1. Frame length and CRC: DEFAULT_DIV=4, status=0, data=24'h000000, pause off.
   - sync low 5 / high 51 ticks.
   - seven 12-tick nibbles.
   - CRC=4'h5, pulse 17 ticks.
   - total 157 ticks = 628 clk_tx.
   - frame_done_o single pulse.
2. Pause: same payload with pause_en_i=1 -> pause pulse 143 ticks; frame exactly 300 ticks.
3. Maximum nibble: data=24'hFFFFFF, status=4'hF.
   - each data and status pulse is 27 ticks.
   - low phase is exactly 5 ticks.
   - CRC matches the reference model.
4. Handshake and back-to-back frames: data_valid_i held high for two payloads.
   - data_ready_o pulses once per frame.
   - the second frame's sync starts on the first tick after frame_done_o.
   - payload changes mid-frame do not alter the transmitted nibbles.
5. Divide reconfiguration: divide_cfg_i 4->8 written mid-frame.
   - divide_o stays 4 until the next data_ready_o, then becomes 8.
6. Reset mid-data-nibble: sent_o=1, busy_o=0, divide_o=DEFAULT_DIV immediately.
   - the next accepted frame starts with a full 56-tick sync.
